// File: rtl/wb_bridge_16to32.sv
// 16-bit big-endian Wishbone master to 32-bit word bus bridge with a one-word
// read line buffer and a slave timeout that converts a dead bus into s_err_o.
module wb_bridge_16to32 #(
    parameter bit BUF_EN  = 1'b1,
    parameter int TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] s_adr_i,
    input  logic [15:0] s_dat_i,
    output logic [15:0] s_dat_o,
    input  logic [1:0]  s_sel_i,
    input  logic        s_we_i,
    input  logic        s_cyc_i,
    input  logic        s_stb_i,
    output logic        s_ack_o,
    output logic        s_err_o,
    input  logic        inval_i,
    output logic [31:0] m_adr_o,
    output logic [31:0] m_dat_o,
    input  logic [31:0] m_dat_i,
    output logic [3:0]  m_sel_o,
    output logic        m_we_o,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    input  logic        m_ack_i,
    input  logic        m_err_i
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t      state_reg, state_next;
    logic [31:1] adr_reg, adr_next;
    logic [3:0]  sel_reg, sel_next;
    logic        we_reg, we_next;
    logic [31:0] dat_reg, dat_next;
    logic [15:0] cnt_reg, cnt_next;
    logic        ack_reg, ack_next;
    logic        err_reg, err_next;
    logic [15:0] sdat_reg, sdat_next;
    logic [31:0] buf_data_reg, buf_data_next;
    logic [29:0] buf_tag_reg, buf_tag_next;
    logic        buf_valid_reg, buf_valid_next;

    logic [31:0] merged;
    logic [3:0]  lane_sel;
    logic        hit;
    logic        in_bus;
    logic        unused_adr_lsb;

    // Halfword 0 of a big-endian word lives in the upper 16 bits.
    function automatic logic [15:0] pick_half(input logic [31:0] w, input logic upper_adr);
        return upper_adr ? w[15:0] : w[31:16];
    endfunction

    assign unused_adr_lsb = s_adr_i[0];
    assign lane_sel = s_adr_i[1] ? {2'b00, s_sel_i} : {s_sel_i, 2'b00};
    assign hit = BUF_EN && !s_we_i && buf_valid_reg && (s_adr_i[31:2] == buf_tag_reg);

    // Write-through merge of the selected byte lanes into the buffered word.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_merge
            assign merged[8*gi +: 8] = sel_reg[gi] ? dat_reg[8*gi +: 8] : buf_data_reg[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        adr_next       = adr_reg;
        sel_next       = sel_reg;
        we_next        = we_reg;
        dat_next       = dat_reg;
        cnt_next       = cnt_reg;
        ack_next       = 1'b0;
        err_next       = 1'b0;
        sdat_next      = sdat_reg;
        buf_data_next  = buf_data_reg;
        buf_tag_next   = buf_tag_reg;
        buf_valid_next = buf_valid_reg;

        case (state_reg)
            IDLE: begin
                if (s_cyc_i && s_stb_i) begin
                    if (hit) begin
                        sdat_next  = pick_half(buf_data_reg, s_adr_i[1]);
                        ack_next   = 1'b1;
                        state_next = RESP;
                    end else begin
                        adr_next   = s_adr_i[31:1];
                        sel_next   = lane_sel;
                        we_next    = s_we_i;
                        dat_next   = {s_dat_i, s_dat_i};
                        cnt_next   = 16'd0;
                        state_next = BUS;
                    end
                end
            end
            BUS: begin
                // A slave response is honoured even if the core aborts the same
                // cycle, so a completed write still keeps the buffer coherent.
                if (m_err_i) begin
                    buf_valid_next = 1'b0;
                    err_next       = 1'b1;
                    state_next     = RESP;
                end else if (m_ack_i) begin
                    if (!we_reg) begin
                        buf_data_next  = m_dat_i;
                        buf_tag_next   = adr_reg[31:2];
                        buf_valid_next = BUF_EN;
                        sdat_next      = pick_half(m_dat_i, adr_reg[1]);
                    end else if (buf_valid_reg && (buf_tag_reg == adr_reg[31:2])) begin
                        buf_data_next = merged;
                    end
                    ack_next   = 1'b1;
                    state_next = RESP;
                end else if (cnt_reg == TMO_LAST) begin
                    buf_valid_next = 1'b0;
                    err_next       = 1'b1;
                    state_next     = RESP;
                end else if (!s_cyc_i) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (inval_i) begin
            buf_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg     <= IDLE;
            adr_reg       <= '0;
            sel_reg       <= '0;
            we_reg        <= 1'b0;
            dat_reg       <= '0;
            cnt_reg       <= '0;
            ack_reg       <= 1'b0;
            err_reg       <= 1'b0;
            sdat_reg      <= '0;
            buf_data_reg  <= '0;
            buf_tag_reg   <= '0;
            buf_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            adr_reg       <= adr_next;
            sel_reg       <= sel_next;
            we_reg        <= we_next;
            dat_reg       <= dat_next;
            cnt_reg       <= cnt_next;
            ack_reg       <= ack_next;
            err_reg       <= err_next;
            sdat_reg      <= sdat_next;
            buf_data_reg  <= buf_data_next;
            buf_tag_reg   <= buf_tag_next;
            buf_valid_reg <= buf_valid_next;
        end
    end

    assign in_bus  = (state_reg == BUS);
    assign m_cyc_o = in_bus;
    assign m_stb_o = in_bus;
    assign m_we_o  = in_bus & we_reg;
    assign m_adr_o = in_bus ? {adr_reg[31:2], 2'b00} : 32'd0;
    assign m_sel_o = in_bus ? sel_reg : 4'd0;
    assign m_dat_o = in_bus ? dat_reg : 32'd0;
    assign s_ack_o = ack_reg;
    assign s_err_o = err_reg;
    assign s_dat_o = sdat_reg;

endmodule
